fpga_cfg_loader: RTL and testbench
==================================

# fpga_cfg_loader

Bitstream loader that sits directly upstream of the FPGA fabric's configuration flip-flop chain. It accepts configuration bytes over a valid/ready byte stream and serialises them MSB-first onto `ccff_head`. While doing so it generates a divided, glitch-free `prog_clk`, counts exactly `CHAIN_LEN` bits and reports done, timeout or error status. It also accumulates parity of the bits shifted out of `ccff_tail`, so a host can check the previous chain contents.

## Interface
- `CHAIN_LEN`, 1024: number of configuration bits in the fabric chain (>= 1).
- `CLK_DIV`, 2: `prog_clk` low time and high time, each in `clk` cycles (>= 1).
- `TIMEOUT`, 65535: maximum `clk` cycles spent waiting for a byte before error (16-bit).

Ports:
- `clk` in 1: single system clock. Everything, including `prog_clk`, is generated from it.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `byte_valid` in 1: the upstream byte is valid.
- `byte_data` in 8: configuration byte. Bit 7 is shifted first.
- `byte_ready` out 1: the loader accepts a byte this cycle.
- `prog_clk` out 1: configuration chain clock, registered.
- `ccff_head` out 1: serial data into the chain, registered.
- `ccff_tail` in 1: serial data out of the chain.
- `busy` out 1: high in WAIT_BYTE, SHIFT_LO and SHIFT_HI.
- `done` out 1: sticky. High after exactly `CHAIN_LEN` bits have been shifted.
- `error` out 1: sticky. High after a byte-wait timeout.
- `tail_parity` out 1: XOR of all `ccff_tail` samples taken during the current or most recent load.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, DONE, ERROR.
- Reset: the state goes to IDLE on the next edge. The following outputs are 0: `prog_clk`, `ccff_head`, `byte_ready`, `busy`, `done`, `error`, `tail_parity`. All counters are cleared.
- IDLE: idle state.
  - `start` moves to WAIT_BYTE.
  - `bit_count`, `tail_parity`, `done` and `error` are cleared.
- WAIT_BYTE:
  - `byte_ready=1`.
  - When `byte_valid` and `byte_ready` are both high:
    - load `byte_data` into an 8-bit shift register;
    - clear `bit_in_byte` and the timeout counter;
    - go to SHIFT_LO.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`, go to ERROR.
- SHIFT_LO:
  - `prog_clk=0`.
  - `ccff_head` equals shift-register bit 7, updated on entry.
  - Held for `CLK_DIV` cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - `prog_clk=1` for `CLK_DIV` cycles. `ccff_head` is stable.
  - On the last cycle:
    - `tail_parity ^= ccff_tail`;
    - `bit_count++` and `bit_in_byte++`.
  - Next state:
    - if `bit_count` reaches `CHAIN_LEN`, go to DONE;
    - else if `bit_in_byte` reaches 8, go to WAIT_BYTE;
    - else shift left by one and go to SHIFT_LO.
- Partial final byte: when `CHAIN_LEN` mod 8 = r ≠ 0, only the upper r bits of the last byte are shifted. The rest are discarded. No further byte is requested.
- DONE:
  - `done=1`, `prog_clk=0`, `byte_ready=0`.
  - `start` restarts the load.
- ERROR:
  - `error=1`, `prog_clk=0`.
  - `start` restarts the load.
- `start` is ignored while `busy=1`.
- `reset` takes priority over everything.
  - Mid-shift reset drives `prog_clk` low on the next edge. The chain contents are then undefined and must be reloaded.
- `bit_count` width is clog2(`CHAIN_LEN`+1).

## Timing
- All outputs are registered. There are no combinational input-to-output paths, except that `byte_ready` is a state decode.
- Handshake to first `prog_clk` rise: `CLK_DIV`+1 cycles. This is one cycle to enter SHIFT_LO plus `CLK_DIV` low cycles.
- `prog_clk` period is 2·`CLK_DIV` cycles within a byte.
- Between bytes the minimum gap adds one WAIT_BYTE cycle. With `byte_valid` held high, each byte costs 16·`CLK_DIV`+1 cycles.
- `ccff_head` changes only on the SHIFT_HI→SHIFT_LO or WAIT_BYTE→SHIFT_LO transition. Setup to the `prog_clk` rise is `CLK_DIV` cycles. Hold after the fall is at least 0 cycles.
- `done` and `error` rise one cycle after the deciding SHIFT_HI cycle or the timeout cycle.
- `byte_ready` drops in the cycle after acceptance.

## Test plan
- **Partial byte load.** `CHAIN_LEN=20`, `CLK_DIV=2`; `start`, then bytes 0xA5, 0x3C, 0xF0.
  - Required: exactly 20 `prog_clk` rises, sampling `ccff_head` = 1010 0101 0011 1100 1111.
  - Exactly 3 handshakes, then `done=1`, `busy=0`, `prog_clk=0`.
- **Back-to-back timing.** `byte_valid` held high.
  - First rise 3 cycles after the handshake.
  - Rise spacing of 4 cycles within a byte and 5 across a byte boundary.
- **Timeout.** `TIMEOUT=50`; one byte is supplied, then `byte_valid` stays low.
  - `error=1` after 50 WAIT_BYTE cycles.
  - `done=0`, 8 rises only, `prog_clk` stays low.
- **Reset mid-shift.** Assert `reset` during bit 10 while `prog_clk=1`.
  - Next cycle: `prog_clk=0`, `busy=0`, `byte_ready=0`.
  - A new `start` then completes a full 20-bit load with `done=1`.
- **Tail parity.** A 20-flop chain model is preloaded with a pattern containing seven 1s.
  - After the load, `tail_parity=1`.
  - The chain model holds the new pattern.
- **Start handling.** A `start` pulse while `busy` has no effect. A `start` in DONE clears `done` and `tail_parity` and reruns the load.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// Configuration bitstream loader: takes bytes over a valid/ready stream,
// shifts them MSB-first onto ccff_head with a divided prog_clk, counts
// CHAIN_LEN bits, and accumulates parity of the bits leaving ccff_tail.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; byte_ready is high only in WAIT_BYTE and does
// not depend on byte_valid, and the producer must hold byte_data stable
// while byte_valid is high and byte_ready is low.
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       tail_parity,
  output logic [2:0] dbg_state
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_SHIFT_LO  = 3'd2,
    S_SHIFT_HI  = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [BCW-1:0] bit_count;
  logic [2:0]     bit_in_byte;
  logic [DW-1:0]  div_cnt;
  logic [15:0]    to_cnt;
  logic [7:0]     shreg;

  logic div_last;
  logic start_ok;

  assign dbg_state = state;
  assign div_last  = (div_cnt == DIV_LAST);
  // A start is only honoured from the non-busy states.
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  // Next-state decode; the last SHIFT_HI cycle decides between done,
  // fetching another byte, or shifting the next bit of the current one.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (byte_valid)            next_state = S_SHIFT_LO;
        else if (to_cnt == TO_LAST) next_state = S_ERROR;
      end
      S_SHIFT_LO:  if (div_last) next_state = S_SHIFT_HI;
      S_SHIFT_HI:  begin
        if (div_last) begin
          if (bit_count == LAST_BIT)  next_state = S_DONE;
          else if (bit_in_byte == 3'd7) next_state = S_WAIT_BYTE;
          else                        next_state = S_SHIFT_LO;
        end
      end
      S_DONE:      if (start) next_state = S_WAIT_BYTE;
      S_ERROR:     if (start) next_state = S_WAIT_BYTE;
      default:     next_state = S_IDLE;
    endcase
  end

  // State register, registered status outputs decoded from the next state,
  // and the shift/count datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      byte_ready  <= 1'b0;
      busy        <= 1'b0;
      prog_clk    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ccff_head   <= 1'b0;
      tail_parity <= 1'b0;
      bit_count   <= '0;
      bit_in_byte <= '0;
      div_cnt     <= '0;
      to_cnt      <= '0;
      shreg       <= '0;
    end else begin
      state      <= next_state;
      byte_ready <= (next_state == S_WAIT_BYTE);
      busy       <= (next_state == S_WAIT_BYTE) || (next_state == S_SHIFT_LO) ||
                    (next_state == S_SHIFT_HI);
      prog_clk   <= (next_state == S_SHIFT_HI);
      done       <= (next_state == S_DONE);
      error      <= (next_state == S_ERROR);

      // Phase counter restarts on every state change so each prog_clk
      // half-period lasts exactly CLK_DIV cycles.
      if (state != next_state)
        div_cnt <= '0;
      else if (state == S_SHIFT_LO || state == S_SHIFT_HI)
        div_cnt <= div_cnt + 1'b1;

      if (state == S_IDLE || start_ok) begin
        bit_count   <= '0;
        tail_parity <= 1'b0;
        to_cnt      <= '0;
      end

      if (state == S_WAIT_BYTE) begin
        if (byte_valid) begin
          shreg       <= byte_data;
          ccff_head   <= byte_data[7];
          bit_in_byte <= '0;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end

      // Tail is sampled on the last high cycle, before the chain sees the
      // falling edge, so it reflects the bit leaving the chain this step.
      if (state == S_SHIFT_HI && div_last) begin
        tail_parity <= tail_parity ^ ccff_tail;
        bit_count   <= bit_count + 1'b1;
        bit_in_byte <= bit_in_byte + 1'b1;
        if (next_state == S_SHIFT_LO) begin
          shreg     <= shreg << 1;
          ccff_head <= shreg[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader with a 20-bit chain, CLK_DIV=2, TIMEOUT=50.
// A behavioural chain model shifts on prog_clk falls using the head value
// captured at the preceding rise.
module tb_fpga_cfg_loader;

  localparam int CL = 20;
  localparam int CD = 2;
  localparam int TO = 50;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       prog_clk;
  logic       ccff_head;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       error;
  logic       tail_parity;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  fpga_cfg_loader #(
    .CHAIN_LEN (CL),
    .CLK_DIV   (CD),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .prog_clk    (prog_clk),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .tail_parity (tail_parity),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [0:0]    exp_q[$];
  int            rise_cyc[$];
  int            hs_cyc[$];
  int            n_wait_idle = 0;

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] preload_val = '0;
  int            preload_tok = 0;
  int            seen_tok = 0;
  logic          pc_prev = 1'b0;
  logic          head_at_rise = 1'b0;

  int bits_left = 0;
  int base_r = 0;
  int base_h = 0;
  int base_w = 0;

  assign ccff_tail = chain[CL-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshakes, prog_clk rises (pop + compare), chain model.
  always @(negedge clk) begin
    if (preload_tok != seen_tok) begin
      chain    = preload_val;
      seen_tok = preload_tok;
    end
    if (byte_valid && byte_ready) hs_cyc.push_back(cyc);
    if (byte_ready && !byte_valid) n_wait_idle++;
    if (prog_clk && !pc_prev) begin
      rise_cyc.push_back(cyc);
      head_at_rise = ccff_head;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rise: prog_clk rose with head=%0b, required no rise", ccff_head);
      end else begin
        check("ccff_head", ccff_head, exp_q.pop_front());
      end
    end
    if (!prog_clk && pc_prev) chain = {chain[CL-2:0], head_at_rise};
    pc_prev = prog_clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    bits_left = CL;
    base_r = rise_cyc.size();
    base_h = hs_cyc.size();
    base_w = n_wait_idle;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    bit got;
    got = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bits_left > 0) begin
        exp_q.push_back(b[i]);
        bits_left--;
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      if (byte_ready) got = 1'b1;
      tick();
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_wait: byte %0h not accepted, required acceptance within 200 cycles", b);
    end
    if (!keep) byte_valid = 1'b0;
  endtask

  task automatic wait_status(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (done || error) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL status_wait: done=%0b error=%0b, required one of them within %0d cycles",
               done, error, max_cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nr;
    bit hit;
    logic pc_seen;
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) tick();

    check("rst_prog_clk", prog_clk, 1'b0);
    check("rst_ccff_head", ccff_head, 1'b0);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_tail_parity", tail_parity, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b0;
    tick();

    // Partial byte load with tail parity: old chain has seven 1s.
    preload_val = 20'hB2144;
    preload_tok++;
    tick();
    do_start();
    check("start_busy", busy, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hF0, 1'b0);
    wait_status(300);
    check("p1_done", done, 1'b1);
    check("p1_error", error, 1'b0);
    check("p1_busy", busy, 1'b0);
    check("p1_prog_clk", prog_clk, 1'b0);
    check("p1_byte_ready", byte_ready, 1'b0);
    check("p1_rises", rise_cyc.size() - base_r, 20);
    check("p1_handshakes", hs_cyc.size() - base_h, 3);
    check("p1_tail_parity", tail_parity, 1'b1);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    repeat (4) tick();
    byte_valid = 1'b0;
    check("p1_no_extra_hs", hs_cyc.size() - base_h, 3);
    check("p1_chain", chain, 20'hA53CF);
    check("p1_exp_empty", exp_q.size(), 0);

    // Restart from DONE, back-to-back bytes, stray start while busy.
    do_start();
    check("rs_done_clr", done, 1'b0);
    check("rs_parity_clr", tail_parity, 1'b0);
    check("rs_busy", busy, 1'b1);
    send_byte(8'h5A, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", busy, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h0F, 1'b1);
    byte_valid = 1'b0;
    wait_status(300);
    check("b2b_done", done, 1'b1);
    nr = rise_cyc.size() - base_r;
    check("b2b_rises", nr, 20);
    check("b2b_handshakes", hs_cyc.size() - base_h, 3);
    if (nr >= 20 && hs_cyc.size() - base_h >= 2) begin
      check("b2b_first_rise", rise_cyc[base_r] - hs_cyc[base_h], 3);
      check("b2b_spacing_in", rise_cyc[base_r+1] - rise_cyc[base_r], 4);
      check("b2b_spacing_b1", rise_cyc[base_r+8] - rise_cyc[base_r+7], 5);
      check("b2b_spacing_b2", rise_cyc[base_r+16] - rise_cyc[base_r+15], 5);
      check("b2b_byte2_rise", rise_cyc[base_r+8] - hs_cyc[base_h+1], 3);
    end
    tick();
    check("b2b_tail_parity", tail_parity, 1'b0);
    check("b2b_chain", chain, 20'h5AC30);

    // Timeout after one byte.
    do_start();
    send_byte(8'h81, 1'b0);
    wait_status(400);
    check("to_error", error, 1'b1);
    check("to_done", done, 1'b0);
    check("to_busy", busy, 1'b0);
    check("to_byte_ready", byte_ready, 1'b0);
    check("to_wait_cycles", n_wait_idle - base_w, TO);
    repeat (10) tick();
    check("to_prog_clk", prog_clk, 1'b0);
    check("to_rises", rise_cyc.size() - base_r, 8);
    check("to_exp_empty", exp_q.size(), 0);

    // Reset during the 10th bit, on its first high cycle.
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    hit = 1'b0;
    pc_seen = prog_clk;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (prog_clk && !pc_seen && (rise_cyc.size() - base_r) == 9) hit = 1'b1;
      else begin
        pc_seen = prog_clk;
        tick();
      end
    end
    check("mid_found_bit10", hit, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_prog_clk", prog_clk, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_byte_ready", byte_ready, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    tick();
    check("mid_idle_state", dbg_state, 3'd0);
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hF0, 1'b0);
    wait_status(300);
    check("mid_reload_done", done, 1'b1);
    check("mid_reload_rises", rise_cyc.size() - base_r, 20);
    check("mid_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000 time units");
    $fatal(1);
  end

endmodule
